// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: binary32 layout, special encodings, divider FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    // Last value of the iteration counter: 26 quotient bits, counted 0..25.
    localparam logic [4:0]  FDIV_LAST_ITER = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_ROUND,
        ST_DONE
    } fdiv_state_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even and range check of a normalised 24-bit mantissa into packed binary32.
// Latency: combinational.
// Backpressure: none; the caller registers the result.
module fp_rne_round
    import fpu_pkg::*;
(
    input  logic               sign,
    input  logic signed [9:0]  exp,
    input  logic [23:0]        mant,
    input  logic               g,
    input  logic               s,
    output logic [31:0]        res,
    output logic               of,
    output logic               uf,
    output logic               nx
);

    logic              inc;
    logic [24:0]       sum;
    logic signed [9:0] exp_adj;
    logic [22:0]       frac;
    fp32_t             packed_res;

    // Round the mantissa, absorb a carry-out into the exponent, then clamp to the normal range.
    always_comb begin
        inc        = g & (s | mant[0]);
        sum        = {1'b0, mant} + {24'd0, inc};
        exp_adj    = exp;
        frac       = sum[22:0];
        if (sum[24]) begin
            // Carry-out only happens from all-ones, so the fraction becomes zero.
            frac    = sum[23:1];
            exp_adj = exp + 10'sd1;
        end
        packed_res = '{sign: sign, exp: exp_adj[7:0], frac: frac};
        of         = 1'b0;
        uf         = 1'b0;
        nx         = g | s;
        if (exp_adj >= 10'sd255) begin
            packed_res = '{sign: sign, exp: FP_INF_EXP, frac: 23'd0};
            of         = 1'b1;
            nx         = 1'b1;
        end else if (exp_adj <= 10'sd0) begin
            // No subnormal outputs: tiny results flush to signed zero.
            packed_res = '{sign: sign, exp: 8'd0, frac: 23'd0};
            uf         = 1'b1;
            nx         = 1'b1;
        end
        res = packed_res;
    end

endmodule

// File: rtl/fdiv_seq.sv
// Sequential binary32 divider (restoring, 1 quotient bit/cycle, RNE); flags port with FDIV_FLAGS_EN.
// Latency: 27 cycles from accept for normal operands, 1 cycle for special operands.
// Backpressure: in_ready only in IDLE; result held stable until out_ready, one op in flight.
module fdiv_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] var1,
    input  logic [31:0] var2,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef FDIV_FLAGS_EN
    output logic [4:0]  flags,
`endif
    output logic [31:0] res
);

    fdiv_state_t       state, state_nx;
    logic [4:0]        cnt;
    logic [25:0]       quo;
    logic [25:0]       rem;
    logic [23:0]       dvsr;
    logic              sign_r;
    logic signed [9:0] exp_r;

    fp32_t       op_a, op_b;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic        res_sign;
    logic        spec_hit, spec_nv, spec_dz;
    logic [31:0] spec_res;

    logic [26:0]       diff;
    logic              qbit;
    logic [25:0]       rem_nx;
    logic [23:0]       n_mant;
    logic              n_g, n_s;
    logic signed [9:0] n_exp;
    logic [31:0]       rnd_res;
    logic              rnd_of, rnd_uf, rnd_nx;

    assign op_a     = var1;
    assign op_b     = var2;
    assign res_sign = op_a.sign ^ op_b.sign;

    // Classify operands; subnormals count as zero.
    always_comb begin
        a_zero = (op_a.exp == 8'd0);
        b_zero = (op_b.exp == 8'd0);
        a_inf  = (op_a.exp == FP_INF_EXP) && (op_a.frac == 23'd0);
        b_inf  = (op_b.exp == FP_INF_EXP) && (op_b.frac == 23'd0);
        a_nan  = (op_a.exp == FP_INF_EXP) && (op_a.frac != 23'd0);
        b_nan  = (op_b.exp == FP_INF_EXP) && (op_b.frac != 23'd0);
    end

    // Special-operand result, in priority order; spec_hit bypasses the iteration.
    always_comb begin
        spec_hit = 1'b1;
        spec_nv  = 1'b0;
        spec_dz  = 1'b0;
        spec_res = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = FP_QNAN;
            spec_nv  = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_res = {res_sign, FP_INF_EXP, 23'd0};
            spec_dz  = 1'b1;
        end else if (a_inf) begin
            spec_res = {res_sign, FP_INF_EXP, 23'd0};
        end else if (b_inf || a_zero) begin
            spec_res = {res_sign, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // One restoring step: subtract if it does not go negative, then shift the remainder.
    always_comb begin
        diff   = {1'b0, rem} - {3'b000, dvsr};
        qbit   = ~diff[26];
        rem_nx = qbit ? {diff[24:0], 1'b0} : {rem[24:0], 1'b0};
    end

    // Normalise the quotient so the integer bit is 1, and split off guard/sticky.
    always_comb begin
        if (quo[25]) begin
            n_mant = quo[25:2];
            n_g    = quo[1];
            n_s    = quo[0] | (|rem);
            n_exp  = exp_r;
        end else begin
            n_mant = quo[24:1];
            n_g    = quo[0];
            n_s    = |rem;
            n_exp  = exp_r - 10'sd1;
        end
    end

    fp_rne_round u_round (
        .sign (sign_r),
        .exp  (n_exp),
        .mant (n_mant),
        .g    (n_g),
        .s    (n_s),
        .res  (rnd_res),
        .of   (rnd_of),
        .uf   (rnd_uf),
        .nx   (rnd_nx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = spec_hit ? ST_DONE : ST_DIV;
            end
            ST_DIV: begin
                if (cnt == FDIV_LAST_ITER) state_nx = ST_ROUND;
            end
            ST_ROUND: state_nx = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in DIV, register the rounded result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 5'd0;
            quo    <= 26'd0;
            rem    <= 26'd0;
            dvsr   <= 24'd0;
            sign_r <= 1'b0;
            exp_r  <= 10'sd0;
            res    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cnt    <= 5'd0;
                        quo    <= 26'd0;
                        rem    <= {2'b00, 1'b1, op_a.frac};
                        dvsr   <= {1'b1, op_b.frac};
                        sign_r <= res_sign;
                        exp_r  <= $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp})
                                  + 10'(FP_BIAS);
                        if (spec_hit) res <= spec_res;
                    end
                end
                ST_DIV: begin
                    rem <= rem_nx;
                    quo <= {quo[24:0], qbit};
                    cnt <= cnt + 5'd1;
                end
                ST_ROUND: res <= rnd_res;
                default: ;
            endcase
        end
    end

`ifdef FDIV_FLAGS_EN
    // Exception flags {NV,DZ,OF,UF,NX}, registered alongside res and cleared on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 5'd0;
        end else begin
            case (state)
                ST_IDLE:  if (in_valid && spec_hit) flags <= {spec_nv, spec_dz, 3'b000};
                ST_ROUND: flags <= {2'b00, rnd_of, rnd_uf, rnd_nx};
                ST_DONE:  if (out_ready) flags <= 5'd0;
                default: ;
            endcase
        end
    end
`else
    logic flags_unused;
    assign flags_unused = ^{spec_nv, spec_dz, rnd_of, rnd_uf, rnd_nx};
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: rounding, specials, range, backpressure and mid-op reset.
// Latency: checks 27-cycle normal and 1-cycle special latency.
// Backpressure: holds out_ready low and checks the result is held.
module tb_fdiv_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] var1;
    logic [31:0] var2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
`ifdef FDIV_FLAGS_EN
    logic [4:0]  flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fdiv_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .var1      (var1),
        .var2      (var2),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FDIV_FLAGS_EN
        .flags     (flags),
`endif
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from an idle DUT; k = edges after the accept edge until out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [4:0] f, output int k);
        var1     = a;
        var2     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout op %h/%h: out_valid=%b after %0d cycles, required 1", a, b, out_valid, k);
        end
        r = res;
`ifdef FDIV_FLAGS_EN
        f = flags;
`else
        f = 5'd0;
`endif
        if (out_ready === 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        var1      = 32'd0;
        var2      = 32'd0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (res !== 32'd0) begin n_fail++; $display("FAIL reset_res got %h want 00000000", res); end
`ifdef FDIV_FLAGS_EN
        n_checks++;
        if (flags !== 5'd0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", flags); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal;
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        run_op(32'h40C00000, 32'h40000000, r, f, k);
        n_checks++;
        if (r !== 32'h40400000) begin n_fail++; $display("FAIL div_6_2 res got %h want 40400000", r); end
        n_checks++;
        if (k !== 27) begin n_fail++; $display("FAIL div_6_2 latency got %0d want 27", k); end
`ifdef FDIV_FLAGS_EN
        n_checks++;
        if (f !== 5'b00000) begin n_fail++; $display("FAIL div_6_2 flags got %b want 00000", f); end
`endif
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL div_6_2 handoff out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_round;
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        run_op(32'h3F800000, 32'h40400000, r, f, k);
        n_checks++;
        if (r !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL div_1_3 res got %h want 3EAAAAAB", r); end
`ifdef FDIV_FLAGS_EN
        n_checks++;
        if (f !== 5'b00001) begin n_fail++; $display("FAIL div_1_3 flags got %b want 00001", f); end
`endif
        run_op(32'hBF800000, 32'h40400000, r, f, k);
        n_checks++;
        if (r !== 32'hBEAAAAAB) begin n_fail++; $display("FAIL div_m1_3 res got %h want BEAAAAAB", r); end
        n_checks++;
        if (k !== 27) begin n_fail++; $display("FAIL div_m1_3 latency got %0d want 27", k); end
    endtask

    task automatic test_specials;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        logic [4:0]  vf [4];
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        va[0] = 32'h3F800000; vb[0] = 32'h00000000; vr[0] = 32'h7F800000; vf[0] = 5'b01000;
        va[1] = 32'hBF800000; vb[1] = 32'h00000000; vr[1] = 32'hFF800000; vf[1] = 5'b01000;
        va[2] = 32'h00000000; vb[2] = 32'h00000000; vr[2] = 32'h7FC00000; vf[2] = 5'b10000;
        va[3] = 32'h7FC00001; vb[3] = 32'h3F800000; vr[3] = 32'h7FC00000; vf[3] = 5'b10000;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], r, f, k);
            n_checks++;
            if (r !== vr[i]) begin n_fail++; $display("FAIL special_%0d res got %h want %h", i, r, vr[i]); end
            n_checks++;
            if (k !== 0) begin n_fail++; $display("FAIL special_%0d latency got %0d want 1", i, k + 1); end
`ifdef FDIV_FLAGS_EN
            n_checks++;
            if (f !== vf[i]) begin n_fail++; $display("FAIL special_%0d flags got %b want %b", i, f, vf[i]); end
`else
            if (vf[i] === 5'bxxxxx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_range;
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        run_op(32'h7F000000, 32'h3E800000, r, f, k);
        n_checks++;
        if (r !== 32'h7F800000) begin n_fail++; $display("FAIL overflow res got %h want 7F800000", r); end
`ifdef FDIV_FLAGS_EN
        n_checks++;
        if (f !== 5'b00101) begin n_fail++; $display("FAIL overflow flags got %b want 00101", f); end
`endif
        run_op(32'h00800000, 32'h40000000, r, f, k);
        n_checks++;
        if (r !== 32'h00000000) begin n_fail++; $display("FAIL underflow res got %h want 00000000", r); end
`ifdef FDIV_FLAGS_EN
        n_checks++;
        if (f !== 5'b00011) begin n_fail++; $display("FAIL underflow flags got %b want 00011", f); end
`endif
        run_op(32'h00000001, 32'h3F800000, r, f, k);
        n_checks++;
        if (r !== 32'h00000000) begin n_fail++; $display("FAIL subnormal res got %h want 00000000", r); end
        n_checks++;
        if (k !== 0) begin n_fail++; $display("FAIL subnormal latency got %0d want 1", k + 1); end
    endtask

    task automatic test_backpressure;
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        out_ready = 1'b0;
        run_op(32'h40C00000, 32'h40000000, r, f, k);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || res !== 32'h40400000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d out_valid=%b res=%h in_ready=%b want 1/40400000/0",
                         i, out_valid, res, in_ready);
            end
`ifdef FDIV_FLAGS_EN
            n_checks++;
            if (flags !== 5'd0) begin n_fail++; $display("FAIL hold_%0d flags got %b want 00000", i, flags); end
`endif
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        run_op(32'h3F800000, 32'h40400000, r, f, k);
        n_checks++;
        if (r !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL second_op res got %h want 3EAAAAAB", r); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] r;
        logic [4:0]  f;
        int          k;
        int          seen;
        var1     = 32'h40C00000;
        var2     = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset in_ready=%b out_valid=%b res=%h want 1/0/00000000", in_ready, out_valid, res);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL stale_out_valid bad cycles got %0d want 0", seen); end
        run_op(32'hBF800000, 32'h40400000, r, f, k);
        n_checks++;
        if (r !== 32'hBEAAAAAB) begin n_fail++; $display("FAIL after_reset res got %h want BEAAAAAB", r); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_round();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
